// File: rtl/sudoku_pkg.sv
// Shared opcode/state types and helpers for the Sudoku candidate cell.
package sudoku_pkg;

   typedef enum logic [2:0] {
      OP_NOP       = 3'd0,
      OP_LOAD      = 3'd1,
      OP_ELIM      = 3'd2,
      OP_READ_VAL  = 3'd3,
      OP_READ_CAND = 3'd4,
      OP_CLEAR     = 3'd5,
      OP_GUESS     = 3'd6,
      OP_RESTORE   = 3'd7
   } cell_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } cell_state_e;

   function automatic int digit_width(input int n);
      return $clog2(n + 1);
   endfunction

   // Only meaningful for one-hot input; zero-based bit position.
   function automatic logic [3:0] onehot_to_index(input logic [15:0] mask);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (mask[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sudoku_cand_stack.sv
// Bounded LIFO holding saved {candidates, value} snapshots for guess/backtrack.
module sudoku_cand_stack #(
   parameter int W     = 13,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top_data,
   output logic         full,
   output logic         empty
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [CW-1:0] count;
   logic [CW-1:0] top_idx;

   assign top_idx  = count - CW'(1);
   assign top_data = mem[top_idx[AW-1:0]];
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + CW'(1);
      end else if (pop && !empty) begin
         count <= count - CW'(1);
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push && !full && !clear) begin
         mem[count[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/sudoku_cand_cell.sv
// One Sudoku grid cell: candidate mask, resolved value, guess stack, and a
// valid/ready command channel returning one response beat per command.
module sudoku_cand_cell
   import sudoku_pkg::*;
#(
   parameter int N     = 9,
   parameter int DEPTH = 4,
   parameter int VW    = digit_width(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [VW-1:0] cmd_data,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [N-1:0]  rsp_data,
   output logic          rsp_err,
   output logic [VW-1:0] value,
   output logic [N-1:0]  candidates,
   output logic          solved,
   output logic          fixed,
   output logic          conflict
);

   cell_state_e   state;
   cell_op_e      op;
   logic          accept;
   logic          bad_digit;
   logic [N-1:0]  digit_onehot;
   logic [N-1:0]  elim_mask;
   logic          elim_onehot;

   logic [VW-1:0] nxt_value;
   logic [N-1:0]  nxt_cand;
   logic          nxt_fixed;
   logic          nxt_conflict;
   logic          nxt_err;
   logic [N-1:0]  nxt_rsp;

   logic          stk_push;
   logic          stk_pop;
   logic          stk_clear;
   logic          stk_full;
   logic          stk_empty;
   logic [N+VW-1:0] stk_top;

   assign op           = cell_op_e'(cmd_op);
   assign accept       = (state == ST_IDLE) && cmd_valid;
   assign bad_digit    = (cmd_data > VW'(N));
   assign digit_onehot = (cmd_data == '0) ? '0
                       : ({{(N-1){1'b0}}, 1'b1} << (cmd_data - VW'(1)));
   assign elim_mask    = candidates & ~digit_onehot;
   assign elim_onehot  = (elim_mask != '0) && ((elim_mask & (elim_mask - N'(1))) == '0);

   // Decode the command into the post-update cell state and response payload.
   always_comb begin
      nxt_value    = value;
      nxt_cand     = candidates;
      nxt_fixed    = fixed;
      nxt_conflict = conflict;
      nxt_err      = 1'b0;
      nxt_rsp      = '0;
      stk_push     = 1'b0;
      stk_pop      = 1'b0;
      stk_clear    = 1'b0;
      case (op)
         OP_LOAD, OP_CLEAR: begin
            if (op == OP_LOAD && bad_digit) begin
               nxt_err = 1'b1;
            end else if (op == OP_CLEAR || cmd_data == '0) begin
               nxt_value    = '0;
               nxt_cand     = '1;
               nxt_fixed    = 1'b0;
               nxt_conflict = 1'b0;
               stk_clear    = 1'b1;
            end else begin
               nxt_value    = cmd_data;
               nxt_cand     = digit_onehot;
               nxt_fixed    = 1'b1;
               nxt_conflict = 1'b0;
               stk_clear    = 1'b1;
            end
         end
         OP_ELIM: begin
            if (bad_digit) begin
               nxt_err = 1'b1;
            end else if (cmd_data != '0) begin
               if (solved && cmd_data == value) begin
                  nxt_conflict = 1'b1;
               end else begin
                  nxt_cand = elim_mask;
                  if (elim_mask == '0) begin
                     nxt_conflict = 1'b1;
                  end else if (!solved && elim_onehot) begin
                     nxt_value = VW'({1'b0, onehot_to_index(16'(elim_mask))} + 5'd1);
                  end
               end
            end
         end
         OP_READ_VAL:  nxt_rsp = N'(value);
         OP_READ_CAND: nxt_rsp = candidates;
         OP_GUESS: begin
            if (bad_digit || cmd_data == '0 || fixed || solved ||
                (candidates & digit_onehot) == '0 || stk_full) begin
               nxt_err = 1'b1;
            end else begin
               stk_push  = 1'b1;
               nxt_value = cmd_data;
               nxt_cand  = digit_onehot;
            end
         end
         OP_RESTORE: begin
            if (stk_empty) begin
               nxt_err = 1'b1;
            end else begin
               stk_pop      = 1'b1;
               nxt_cand     = stk_top[N+VW-1:VW];
               nxt_value    = stk_top[VW-1:0];
               nxt_conflict = 1'b0;
            end
         end
         default: ;
      endcase
   end

   sudoku_cand_stack #(
      .W     (N + VW),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (accept && stk_clear),
      .push      (accept && stk_push),
      .pop       (accept && stk_pop),
      .push_data ({candidates, value}),
      .top_data  (stk_top),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   // Handshake FSM; cell state and response are captured only on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         value      <= '0;
         candidates <= '1;
         solved     <= 1'b0;
         fixed      <= 1'b0;
         conflict   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  state      <= ST_RESP;
                  cmd_ready  <= 1'b0;
                  rsp_valid  <= 1'b1;
                  rsp_data   <= nxt_rsp;
                  rsp_err    <= nxt_err;
                  value      <= nxt_value;
                  candidates <= nxt_cand;
                  solved     <= (nxt_value != '0);
                  fixed      <= nxt_fixed;
                  conflict   <= nxt_conflict;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state     <= ST_IDLE;
                  cmd_ready <= 1'b1;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
